// File: rtl/friscv_pmp_csr.sv
// PMP CSR register file: serves pmpcfg/pmpaddr read-modify-write requests,
// applies WARL and lock rules, and exposes the flattened state to the MPU.
module friscv_pmp_csr #(
  parameter int XLEN       = 32,
  parameter int NB_ENTRIES = 4
) (
  input  logic                       aclk,
  input  logic                       srst,
  input  logic                       csr_valid,
  output logic                       csr_ready,
  input  logic [2:0]                 csr_funct3,
  input  logic [11:0]                csr_addr,
  input  logic [XLEN-1:0]            csr_wdata,
  output logic                       csr_rvalid,
  output logic [XLEN-1:0]            csr_rdata,
  output logic                       csr_err,
  output logic [8*NB_ENTRIES-1:0]    pmpcfg_o,
  output logic [XLEN*NB_ENTRIES-1:0] pmpaddr_o
);

  typedef enum logic [1:0] {IDLE, MODIFY, RESP} state_t;

  state_t          r_state;
  logic            r_ready;
  logic            r_rvalid;
  logic [XLEN-1:0] r_rdata;
  logic            r_err;
  logic [2:0]      r_funct3;
  logic [11:0]     r_csrAddr;
  logic [XLEN-1:0] r_wdata;
  logic [7:0]      r_cfg  [NB_ENTRIES];
  logic [XLEN-1:0] r_addr [NB_ENTRIES];

  logic                  w_inMap;
  logic                  w_isCfg;
  logic                  w_isAddr;
  logic [XLEN-1:0]       w_oldVal;
  logic [XLEN-1:0]       w_newVal;
  logic                  w_doWrite;
  logic [NB_ENTRIES-1:0] w_torLock;

  // R=0 with W=1 is a reserved combination, so W is dropped; bits 6:5 are reserved.
  function automatic logic [7:0] warlCfg(input logic [7:0] b);
    return {b[7], 2'b00, b[4:3], b[2], b[1] & b[0], b[0]};
  endfunction

  assign w_inMap  = (r_csrAddr[11:5] == 7'h1D);
  assign w_isCfg  = (r_csrAddr[11:4] == 8'h3A) && (r_csrAddr[3:2] == 2'b00);
  assign w_isAddr = (r_csrAddr[11:4] == 8'h3B);

  always_comb begin
    w_oldVal = '0;
    for (int i = 0; i < NB_ENTRIES; i++) begin
      if (w_isCfg && (r_csrAddr[1:0] == 2'(i / 4)))
        w_oldVal[8*(i%4) +: 8] = r_cfg[i];
      if (w_isAddr && (r_csrAddr[3:0] == 4'(i)))
        w_oldVal = r_addr[i];
    end
  end

  // RS/RC with a zero operand are pure reads and must not touch state.
  always_comb begin
    w_newVal  = w_oldVal;
    w_doWrite = 1'b0;
    casez (r_funct3)
      3'b?01: begin
        w_newVal  = r_wdata;
        w_doWrite = w_inMap;
      end
      3'b?10: begin
        w_newVal  = w_oldVal | r_wdata;
        w_doWrite = w_inMap && (r_wdata != '0);
      end
      3'b?11: begin
        w_newVal  = w_oldVal & ~r_wdata;
        w_doWrite = w_inMap && (r_wdata != '0);
      end
      default: begin
        w_newVal  = w_oldVal;
        w_doWrite = 1'b0;
      end
    endcase
  end

  for (genvar g = 0; g < NB_ENTRIES; g++) begin : gEntry
    if (g + 1 < NB_ENTRIES) begin : gTor
      assign w_torLock[g] = r_cfg[g+1][7] && (r_cfg[g+1][4:3] == 2'b01);
    end else begin : gLast
      assign w_torLock[g] = 1'b0;
    end
    assign pmpcfg_o[8*g +: 8]        = r_cfg[g];
    assign pmpaddr_o[XLEN*g +: XLEN] = r_addr[g];
  end

  always_ff @(posedge aclk) begin
    if (srst) begin
      r_state   <= IDLE;
      r_ready   <= 1'b1;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
      r_funct3  <= '0;
      r_csrAddr <= '0;
      r_wdata   <= '0;
      for (int i = 0; i < NB_ENTRIES; i++) begin
        r_cfg[i]  <= '0;
        r_addr[i] <= '0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          r_rvalid <= 1'b0;
          if (csr_valid) begin
            r_funct3  <= csr_funct3;
            r_csrAddr <= csr_addr;
            r_wdata   <= csr_wdata;
            r_ready   <= 1'b0;
            r_state   <= MODIFY;
          end
        end
        MODIFY: begin
          // Lock checks read the pre-write cfg values, so setting L still lands.
          for (int i = 0; i < NB_ENTRIES; i++) begin
            if (w_doWrite && w_isCfg && (r_csrAddr[1:0] == 2'(i / 4)) && !r_cfg[i][7])
              r_cfg[i] <= warlCfg(w_newVal[8*(i%4) +: 8]);
            if (w_doWrite && w_isAddr && (r_csrAddr[3:0] == 4'(i)) &&
                !r_cfg[i][7] && !w_torLock[i])
              r_addr[i] <= w_newVal;
          end
          r_rdata  <= w_oldVal;
          r_err    <= !w_inMap;
          r_rvalid <= 1'b1;
          r_state  <= RESP;
        end
        RESP: begin
          r_rvalid <= 1'b0;
          r_ready  <= 1'b1;
          r_state  <= IDLE;
        end
        default: begin
          r_rvalid <= 1'b0;
          r_ready  <= 1'b1;
          r_state  <= IDLE;
        end
      endcase
    end
  end

  assign csr_ready  = r_ready;
  assign csr_rvalid = r_rvalid;
  assign csr_rdata  = r_rdata;
  assign csr_err    = r_err;

endmodule

// File: tb/tb_friscv_pmp_csr.sv
// Directed bench for friscv_pmp_csr: handshake latency, WARL, locks,
// address decode and reset abort, all with hand-computed expectations.
module tb_friscv_pmp_csr;
  localparam int XLEN = 32;
  localparam int NB   = 4;

  logic              aclk = 1'b0;
  logic              srst;
  logic              csrValid;
  logic              csrReady;
  logic [2:0]        csrFunct3;
  logic [11:0]       csrAddr;
  logic [XLEN-1:0]   csrWdata;
  logic              csrRvalid;
  logic [XLEN-1:0]   csrRdata;
  logic              csrErr;
  logic [8*NB-1:0]   pmpcfgO;
  logic [XLEN*NB-1:0] pmpaddrO;

  int checks = 0;
  int errors = 0;

  logic [31:0] rd;
  logic        er;

  friscv_pmp_csr #(.XLEN(XLEN), .NB_ENTRIES(NB)) dut (
    .aclk       (aclk),
    .srst       (srst),
    .csr_valid  (csrValid),
    .csr_ready  (csrReady),
    .csr_funct3 (csrFunct3),
    .csr_addr   (csrAddr),
    .csr_wdata  (csrWdata),
    .csr_rvalid (csrRvalid),
    .csr_rdata  (csrRdata),
    .csr_err    (csrErr),
    .pmpcfg_o   (pmpcfgO),
    .pmpaddr_o  (pmpaddrO)
  );

  always #5 aclk = ~aclk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%h expected 0x%h", tag, observed, expected);
    end
  endtask

  // One full request: waits (bounded) for ready, then checks the rvalid pulse timing.
  task automatic applyStimulus(input string tag, input logic [2:0] f3, input logic [11:0] addr,
                               input logic [31:0] wd, output logic [31:0] rdOut, output logic errOut);
    int waitCycles;
    @(negedge aclk);
    csrValid  = 1'b1;
    csrFunct3 = f3;
    csrAddr   = addr;
    csrWdata  = wd;
    waitCycles = 0;
    while (!csrReady && waitCycles < 20) begin
      @(negedge aclk);
      waitCycles++;
    end
    checkOutput({tag, "_ready"}, {31'b0, csrReady}, 32'd1);
    @(posedge aclk);
    @(negedge aclk);
    csrValid = 1'b0;
    checkOutput({tag, "_lat1"}, {31'b0, csrRvalid}, 32'd0);
    @(negedge aclk);
    checkOutput({tag, "_rvalid"}, {31'b0, csrRvalid}, 32'd1);
    rdOut  = csrRdata;
    errOut = csrErr;
    @(negedge aclk);
    checkOutput({tag, "_pulse"}, {31'b0, csrRvalid}, 32'd0);
    checkOutput({tag, "_hold"}, csrRdata, rdOut);
  endtask

  task automatic doReset();
    srst = 1'b1;
    repeat (3) @(negedge aclk);
    srst = 1'b0;
  endtask

  initial begin
    srst      = 1'b1;
    csrValid  = 1'b0;
    csrFunct3 = 3'b000;
    csrAddr   = 12'h000;
    csrWdata  = '0;
    doReset();

    checkOutput("rst_ready",  {31'b0, csrReady},  32'd1);
    checkOutput("rst_rvalid", {31'b0, csrRvalid}, 32'd0);
    checkOutput("rst_rdata",  csrRdata,           32'd0);
    checkOutput("rst_err",    {31'b0, csrErr},    32'd0);
    checkOutput("rst_cfg",    pmpcfgO,            32'd0);
    checkOutput("rst_addr0",  pmpaddrO[31:0],     32'd0);
    checkOutput("rst_addr3",  pmpaddrO[127:96],   32'd0);

    applyStimulus("rd3A0", 3'b010, 12'h3A0, 32'h0, rd, er);
    checkOutput("rd3A0_data", rd, 32'h0);
    checkOutput("rd3A0_err",  {31'b0, er}, 32'd0);

    applyStimulus("rw3B1", 3'b001, 12'h3B1, 32'h2000_0000, rd, er);
    checkOutput("rw3B1_old", rd, 32'h0);
    checkOutput("rw3B1_out", pmpaddrO[63:32], 32'h2000_0000);
    applyStimulus("rs3B1", 3'b010, 12'h3B1, 32'h0, rd, er);
    checkOutput("rs3B1_data", rd, 32'h2000_0000);

    applyStimulus("warl", 3'b001, 12'h3A0, 32'h0000_FF62, rd, er);
    checkOutput("warl_cfg", pmpcfgO, 32'h0000_9F00);
    applyStimulus("warlRd", 3'b110, 12'h3A0, 32'h0, rd, er);
    checkOutput("warl_rd", rd, 32'h0000_9F00);

    // Fresh state so entry 1 starts unlocked before the lock scenario.
    doReset();
    applyStimulus("pa0", 3'b001, 12'h3B0, 32'h0000_AAAA, rd, er);
    applyStimulus("pa1", 3'b001, 12'h3B1, 32'h0000_5555, rd, er);
    applyStimulus("lock", 3'b001, 12'h3A0, 32'h0000_8900, rd, er);
    checkOutput("lock_cfg", pmpcfgO, 32'h0000_8900);
    applyStimulus("torPa0", 3'b001, 12'h3B0, 32'h0000_1234, rd, er);
    checkOutput("torPa0_old", rd, 32'h0000_AAAA);
    checkOutput("torPa0_out", pmpaddrO[31:0], 32'h0000_AAAA);
    applyStimulus("lkPa1", 3'b101, 12'h3B1, 32'h0000_9999, rd, er);
    checkOutput("lkPa1_old", rd, 32'h0000_5555);
    checkOutput("lkPa1_out", pmpaddrO[63:32], 32'h0000_5555);
    applyStimulus("lkRc", 3'b011, 12'h3A0, 32'h0000_FF00, rd, er);
    checkOutput("lkRc_old", rd, 32'h0000_8900);
    checkOutput("lkRc_cfg", pmpcfgO, 32'h0000_8900);
    applyStimulus("lkB0", 3'b001, 12'h3A0, 32'h0000_FF07, rd, er);
    checkOutput("lkB0_cfg", pmpcfgO, 32'h0000_8907);
    applyStimulus("pa2", 3'b001, 12'h3B2, 32'h0000_0077, rd, er);
    checkOutput("pa2_out", pmpaddrO[95:64], 32'h0000_0077);

    applyStimulus("ill", 3'b001, 12'h300, 32'h0000_FFFF, rd, er);
    checkOutput("ill_data", rd, 32'h0);
    checkOutput("ill_err",  {31'b0, er}, 32'd1);
    checkOutput("ill_cfg",  pmpcfgO, 32'h0000_8907);
    checkOutput("ill_addr0", pmpaddrO[31:0], 32'h0000_AAAA);

    applyStimulus("un3B5", 3'b001, 12'h3B5, 32'h0000_DEAD, rd, er);
    checkOutput("un3B5_err", {31'b0, er}, 32'd0);
    applyStimulus("un3B5r", 3'b010, 12'h3B5, 32'h0, rd, er);
    checkOutput("un3B5r_data", rd, 32'h0);
    applyStimulus("un3A1", 3'b001, 12'h3A1, 32'h1234_5678, rd, er);
    applyStimulus("un3A1r", 3'b010, 12'h3A1, 32'h0, rd, er);
    checkOutput("un3A1r_data", rd, 32'h0);
    checkOutput("un3A1r_err",  {31'b0, er}, 32'd0);

    // Abort a request in MODIFY with reset: no response, no commit.
    @(negedge aclk);
    csrValid  = 1'b1;
    csrFunct3 = 3'b001;
    csrAddr   = 12'h3B2;
    csrWdata  = 32'h0000_BEEF;
    checkOutput("abort_ready0", {31'b0, csrReady}, 32'd1);
    @(posedge aclk);
    @(negedge aclk);
    csrValid = 1'b0;
    srst     = 1'b1;
    @(negedge aclk);
    srst = 1'b0;
    checkOutput("abort_ready", {31'b0, csrReady},  32'd1);
    checkOutput("abort_rv0",   {31'b0, csrRvalid}, 32'd0);
    checkOutput("abort_pa2",   pmpaddrO[95:64],    32'd0);
    @(negedge aclk);
    checkOutput("abort_rv1",   {31'b0, csrRvalid}, 32'd0);
    checkOutput("abort_cfg",   pmpcfgO,            32'd0);

    applyStimulus("unlk", 3'b001, 12'h3B1, 32'h0000_1111, rd, er);
    checkOutput("unlk_out", pmpaddrO[63:32], 32'h0000_1111);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
